// File: rtl/i2c_bus_master_phy_if.sv
// Command/response bundle between the byte-level I2C controller (master) and the bit-level PHY (slave).
interface i2c_bus_master_phy_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_wdata;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       rsp_rdata;
  logic       arb_lost;
  logic       bus_busy;
  logic       start_det;
  logic       stop_det;

  modport master (output cmd_valid, cmd, cmd_wdata,
                  input  cmd_ready, rsp_valid, rsp_rdata, arb_lost, bus_busy, start_det, stop_det);
  modport slave  (input  cmd_valid, cmd, cmd_wdata,
                  output cmd_ready, rsp_valid, rsp_rdata, arb_lost, bus_busy, start_det, stop_det);
endinterface

// File: rtl/i2c_bus_master_phy.sv
// Bit-level I2C master PHY: quarter-period sequencer, open-drain pads, stretch/arbitration, START/STOP detect.
// Define I2C_GLITCH_FILTER_EN to insert a FILTER_LEN-cycle stability filter after the synchronisers.
module i2c_bus_master_phy #(
  parameter int CLK_DIV     = 250,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                clk,
  input  logic                rst,
  i2c_bus_master_phy_if.slave bus,
  inout  wire                 SCL,
  inout  wire                 SDA
);
  typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3} state_e;
  // cmd encoding: 00 START, 01 STOP, 10 WRITE, 11 READ (bit 1 = data bit command)
  localparam logic [1:0] C_START = 2'b00, C_STOP = 2'b01, C_WRITE = 2'b10;
  localparam int CW = $clog2(CLK_DIV);
`ifdef I2C_GLITCH_FILTER_EN
  localparam bit FLT_EN = 1'b1;
`else
  localparam bit FLT_EN = 1'b0;
`endif
  localparam int IN_LAT   = SYNC_STAGES + (FLT_EN ? FILTER_LEN : 0);
  // Stall point in Q1 sits after the input latency, so an unstretched SCL keeps its nominal high time.
  localparam int STALL_AT = (IN_LAT < CLK_DIV - 1) ? IN_LAT : CLK_DIV - 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_STALL = CW'(STALL_AT);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic wdata_q, wdata_d, rdata_q, rdata_d, rsp_valid_q, rsp_valid_d, arb_q, arb_d;
  logic scl_hold_q, scl_hold_d, sda_hold_q, sda_hold_d;
  logic sda_prev_q, start_det_q, stop_det_q, bus_busy_q;
  logic start_c, stop_c, scl_oe, sda_oe, cmd_ready;

`ifdef I2C_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [1:0] flt_in, flt_q;
  logic [1:0][FW-1:0] fcnt_q;
  assign flt_in = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_q  <= '1;
      fcnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (flt_in[i] == flt_q[i]) fcnt_q[i] <= '0;
        else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          flt_q[i]  <= flt_in[i];
          fcnt_q[i] <= '0;
        end else fcnt_q[i] <= fcnt_q[i] + 1'b1;
      end
    end
  end
  assign scl_s = flt_q[1];
  assign sda_s = flt_q[0];
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  assign start_c   = sda_prev_q & ~sda_s & scl_s;
  assign stop_c    = ~sda_prev_q & sda_s & scl_s;
  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    arb_d       = 1'b0;
    scl_hold_d  = scl_hold_q;
    sda_hold_d  = sda_hold_q;
    if (state_q == IDLE) begin
      if (bus.cmd_valid && cmd_ready) begin
        cmd_d   = bus.cmd;
        wdata_d = bus.cmd_wdata;
        cnt_d   = '0;
        state_d = Q0;
      end
    end else if (!(state_q == Q1 && cnt_q == CNT_STALL && !scl_s)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        case (state_q)
          Q0:      state_d = Q1;
          Q1:      state_d = Q2;
          Q2:      state_d = Q3;
          default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            scl_hold_d  = scl_oe;
            sda_hold_d  = sda_oe;
          end
        endcase
        if (state_q == Q2 && cmd_q[1]) rdata_d = sda_s;
        if (!sda_s && ((state_q == Q1 && cmd_q == C_START) ||
                       (state_q == Q2 && cmd_q == C_WRITE && wdata_q))) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          arb_d       = 1'b1;
          scl_hold_d  = 1'b0;
          sda_hold_d  = 1'b0;
        end
      end
    end
  end

  // IDLE keeps the levels left by the last command so SCL stays low between data bits.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    if (state_q == IDLE) begin
      scl_oe = scl_hold_q;
      sda_oe = sda_hold_q;
    end else begin
      case (cmd_q)
        C_START: begin sda_oe = state_q inside {Q2, Q3}; scl_oe = (state_q == Q3); end
        C_STOP:  begin sda_oe = (state_q != Q3);         scl_oe = (state_q == Q0); end
        C_WRITE: begin sda_oe = !wdata_q;                scl_oe = state_q inside {Q0, Q3}; end
        default: scl_oe = state_q inside {Q0, Q3};
      endcase
    end
  end

  assign SCL = scl_oe ? 1'b0 : 1'bz;
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= C_START;
      wdata_q     <= 1'b0;
      rdata_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      arb_q       <= 1'b0;
      scl_hold_q  <= 1'b0;
      sda_hold_q  <= 1'b0;
      sda_prev_q  <= 1'b1;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      bus_busy_q  <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      arb_q       <= arb_d;
      scl_hold_q  <= scl_hold_d;
      sda_hold_q  <= sda_hold_d;
      sda_prev_q  <= sda_s;
      start_det_q <= start_c;
      stop_det_q  <= stop_c;
      if (stop_c)       bus_busy_q <= 1'b0;
      else if (start_c) bus_busy_q <= 1'b1;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.arb_lost  = arb_q;
  assign bus.bus_busy  = bus_busy_q;
  assign bus.start_det = start_det_q;
  assign bus.stop_det  = stop_det_q;
endmodule
